// File: rtl/mcs_io_pkg.sv
// Shared types for the MCS IO bus initiator: FSM states, response error codes
// and the address-window test.
package mcs_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_TMO  = 2'b01,
        ERR_ADDR = 2'b10
    } err_t;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mcs_io_initiator_timer.sv
// Ready-wait timer: counts cycles since the strobe cycle and flags when the
// slave has had TIMEOUT wait cycles without answering.
module io_timeout_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Saturates at TIMEOUT so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_MAX);

endmodule

// File: rtl/mcs_io_initiator.sv
// MCS IO bus initiator: converts a valid/ready command stream into single IO
// bus transactions with window check and ready timeout; results on rsp stream.
module mcs_io_initiator
    import mcs_io_pkg::*;
#(
    parameter logic [31:0] WIN_BASE = 32'hc000_0000,
    parameter logic [31:0] WIN_MASK = 32'hc000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [31:0] io_address,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready
);

    state_t      r_state;
    err_t        r_err;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic        r_addr_strobe;
    logic        r_rd_strobe;
    logic        r_wr_strobe;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_be;

    logic        w_busy;
    logic        w_expired;

    // The timer runs from the strobe cycle onward, so in wait cycle k it reads k.
    assign w_busy = (r_state == STROBE) || (r_state == WAIT);

    io_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_busy),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    // NOTE: the bus-facing datapath registers are reset too, so io_address and
    // friends show a defined 0 after reset instead of stale contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_err         <= ERR_OK;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_addr_strobe <= 1'b0;
            r_rd_strobe   <= 1'b0;
            r_wr_strobe   <= 1'b0;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_be          <= '0;
        end else begin
            r_addr_strobe <= 1'b0;
            r_rd_strobe   <= 1'b0;
            r_wr_strobe   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_wr        <= cmd_wr;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wr ? cmd_wdata : 32'h0;
                        r_be        <= cmd_wr ? cmd_be : 4'hf;
                        if (in_window(cmd_addr, WIN_BASE, WIN_MASK)) begin
                            r_state       <= STROBE;
                            r_addr_strobe <= 1'b1;
                            r_rd_strobe   <= !cmd_wr;
                            r_wr_strobe   <= cmd_wr;
                        end else begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_err       <= ERR_ADDR;
                            r_rdata     <= '0;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                STROBE, WAIT: begin
                    // A ready arriving together with expiry still completes normally.
                    if (io_ready) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_err       <= ERR_OK;
                        r_rdata     <= r_wr ? 32'h0 : io_read_data;
                    end else if (w_expired) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_err       <= ERR_TMO;
                        r_rdata     <= '0;
                    end else begin
                        r_state <= WAIT;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rdata;
    assign rsp_err         = r_err;
    assign io_addr_strobe  = r_addr_strobe;
    assign io_read_strobe  = r_rd_strobe;
    assign io_write_strobe = r_wr_strobe;
    assign io_address      = r_addr;
    assign io_byte_enable  = r_be;
    assign io_write_data   = r_wdata;

endmodule

// File: tb/tb_mcs_io_initiator.sv
// Self-checking bench for mcs_io_initiator: transaction-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mcs_io_initiator;

    localparam int          TMO   = 4;
    localparam logic [31:0] WBASE = 32'hc000_0000;
    localparam logic [31:0] WMASK = 32'hc000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [31:0] io_address;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data = '0;
    logic        io_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;

    always #5 clk = ~clk;

    mcs_io_initiator #(
        .WIN_BASE (WBASE),
        .WIN_MASK (WMASK),
        .TIMEOUT  (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_wr          (cmd_wr),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_be          (cmd_be),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_address      (io_address),
        .io_byte_enable  (io_byte_enable),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding command, tracked by how many
    // cycles have passed since its strobe cycle.
    logic        m_live = 1'b0;
    logic        m_cmd_ready = 1'b0;
    logic        m_rsp_valid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_err = '0;
    logic        m_strobe = 1'b0;
    logic        m_rd = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_addr = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_wdata = '0;
    logic        m_txn = 1'b0;
    logic        m_is_wr = 1'b0;
    int          m_waited = 0;

    always @(posedge clk) begin
        m_live   <= 1'b1;
        m_strobe <= 1'b0;
        m_rd     <= 1'b0;
        m_wr     <= 1'b0;
        if (reset) begin
            m_cmd_ready <= 1'b0;
            m_rsp_valid <= 1'b0;
            m_rdata     <= '0;
            m_err       <= 2'b00;
            m_addr      <= '0;
            m_be        <= '0;
            m_wdata     <= '0;
            m_txn       <= 1'b0;
            m_waited    <= 0;
        end else if (m_rsp_valid) begin
            if (rsp_ready) begin
                m_rsp_valid <= 1'b0;
                m_cmd_ready <= 1'b1;
            end
        end else if (m_txn) begin
            if (io_ready) begin
                m_txn       <= 1'b0;
                m_rsp_valid <= 1'b1;
                m_err       <= 2'b00;
                m_rdata     <= m_is_wr ? 32'h0 : io_read_data;
            end else if (m_waited == TMO) begin
                m_txn       <= 1'b0;
                m_rsp_valid <= 1'b1;
                m_err       <= 2'b01;
                m_rdata     <= '0;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (m_cmd_ready && cmd_valid) begin
            m_cmd_ready <= 1'b0;
            m_addr      <= cmd_addr;
            m_is_wr     <= cmd_wr;
            m_be        <= cmd_wr ? cmd_be : 4'hf;
            m_wdata     <= cmd_wdata;
            if ((cmd_addr & WMASK) == WBASE) begin
                m_txn    <= 1'b1;
                m_waited <= 0;
                m_strobe <= 1'b1;
                m_rd     <= !cmd_wr;
                m_wr     <= cmd_wr;
            end else begin
                m_rsp_valid <= 1'b1;
                m_err       <= 2'b10;
                m_rdata     <= '0;
            end
        end else begin
            m_cmd_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        strobe_cnt = strobe_cnt + int'(io_addr_strobe);
        if (m_live) begin
            check("mdl_cmd_ready", 32'(cmd_ready), 32'(m_cmd_ready));
            check("mdl_rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            check("mdl_addr_strobe", 32'(io_addr_strobe), 32'(m_strobe));
            check("mdl_read_strobe", 32'(io_read_strobe), 32'(m_rd));
            check("mdl_write_strobe", 32'(io_write_strobe), 32'(m_wr));
            if (m_rsp_valid) begin
                check("mdl_rsp_rdata", rsp_rdata, m_rdata);
                check("mdl_rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (m_txn) begin
                check("mdl_io_address", io_address, m_addr);
                check("mdl_io_be", 32'(io_byte_enable), 32'(m_be));
                if (m_is_wr) check("mdl_io_wdata", io_write_data, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns 1 time unit after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_be    = be;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int first;
        logic seen;

        repeat (3) tick();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_strobes", {29'd0, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'd0);
        check("rst_io_address", io_address, 32'd0);
        check("rst_io_be", 32'(io_byte_enable), 32'd0);
        check("rst_io_wdata", io_write_data, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();

        // Zero-wait write against an always-ready slave.
        io_ready = 1'b1;
        s0 = strobe_cnt;
        send_cmd(1'b1, 32'hc000_0010, 32'h1234_5678, 4'hf);
        @(negedge clk);
        check("zw_addr_strobe", 32'(io_addr_strobe), 32'd1);
        check("zw_write_strobe", 32'(io_write_strobe), 32'd1);
        check("zw_read_strobe", 32'(io_read_strobe), 32'd0);
        check("zw_io_address", io_address, 32'hc000_0010);
        check("zw_io_wdata", io_write_data, 32'h1234_5678);
        @(negedge clk);
        check("zw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("zw_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        io_ready = 1'b0;
        check("zw_one_strobe", 32'(strobe_cnt - s0), 32'd1);

        // Read answered in the third wait cycle.
        s0 = strobe_cnt;
        send_cmd(1'b0, 32'hc000_0024, 32'h0, 4'h3);
        @(negedge clk);
        check("rd_read_strobe", 32'(io_read_strobe), 32'd1);
        check("rd_be_forced", 32'(io_byte_enable), 32'hf);
        tick();
        tick();
        tick();
        io_ready     = 1'b1;
        io_read_data = 32'hdead_beef;
        @(negedge clk);
        check("rd_addr_held", io_address, 32'hc000_0024);
        check("rd_no_strobe_in_wait", 32'(io_addr_strobe), 32'd0);
        tick();
        io_ready     = 1'b0;
        io_read_data = '0;
        @(negedge clk);
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", rsp_rdata, 32'hdead_beef);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        check("rd_one_strobe", 32'(strobe_cnt - s0), 32'd1);

        // Silent slave: response after strobe plus TMO wait cycles.
        send_cmd(1'b0, 32'hc000_0100, 32'h0, 4'hf);
        seen  = 1'b0;
        first = 0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen  = 1'b1;
                first = n;
            end
        end
        check("tmo_latency", 32'(first), 32'd6);
        check("tmo_rsp_err", 32'(rsp_err), 32'd1);
        check("tmo_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        tick();
        tick();
        io_ready     = 1'b1;
        io_read_data = 32'h5555_aaaa;
        tick();
        io_ready     = 1'b0;
        io_read_data = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("late_ready_ignored", 32'(rsp_valid), 32'd0);
        end
        tick();

        // Out-of-window read: no strobe, immediate address error.
        s0 = strobe_cnt;
        send_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hf);
        @(negedge clk);
        check("oow_rsp_valid", 32'(rsp_valid), 32'd1);
        check("oow_rsp_err", 32'(rsp_err), 32'd2);
        check("oow_rsp_rdata", rsp_rdata, 32'd0);
        check("oow_no_strobe", 32'(io_addr_strobe), 32'd0);
        tick();
        check("oow_strobe_count", 32'(strobe_cnt - s0), 32'd0);

        // Backpressure with the next command already waiting.
        rsp_ready = 1'b0;
        io_ready  = 1'b1;
        send_cmd(1'b1, 32'hc000_0040, 32'ha5a5_0001, 4'h5);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 32'hc000_0044;
        cmd_wdata = 32'h0bad_f00d;
        cmd_be    = 4'hc;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_err", 32'(rsp_err), 32'd0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_cmd_ready_pre_hs", 32'(cmd_ready), 32'd0);
        tick();
        @(negedge clk);
        check("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_next_strobe", 32'(io_write_strobe), 32'd1);
        check("bp_next_address", io_address, 32'hc000_0044);
        tick();
        tick();
        io_ready = 1'b0;

        // Reset while waiting for the slave.
        send_cmd(1'b0, 32'hc000_0080, 32'h0, 4'hf);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rstw_strobes", {29'd0, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'd0);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        reset        = 1'b0;
        io_ready     = 1'b1;
        io_read_data = 32'h1111_2222;
        tick();
        io_ready     = 1'b0;
        io_read_data = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rstw_ready_ignored", 32'(rsp_valid), 32'd0);
        end
        tick();
        send_cmd(1'b0, 32'hc000_0090, 32'h0, 4'hf);
        tick();
        io_ready     = 1'b1;
        io_read_data = 32'h7777_8888;
        tick();
        io_ready     = 1'b0;
        io_read_data = '0;
        @(negedge clk);
        check("rstw_next_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rstw_next_rdata", rsp_rdata, 32'h7777_8888);
        check("rstw_next_err", 32'(rsp_err), 32'd0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
